// File: rtl/serial_chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder_pkg
// Shared types and helpers for the serial chunk adder.
//   state_t      : controller states (IDLE, BUSY, DONE)
//   num_chunks() : number of CHUNK-bit slices in a WIDTH-bit word
//   idx_width()  : width of the chunk index counter (at least 1 bit)
// ---------------------------------------------------------------------------
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;
    localparam int DEFAULT_IDX_W = idx_width(num_chunks(DEFAULT_WIDTH, DEFAULT_CHUNK));

endpackage

// File: rtl/serial_chunk_adder_ripple.sv
// ---------------------------------------------------------------------------
// ripple_chunk_adder
// Combinational CHUNK-bit ripple-carry adder used for one slice per cycle.
//   x, y     : chunk operands
//   ci       : carry into bit 0
//   s        : chunk sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (for signed overflow detection)
// ---------------------------------------------------------------------------
module ripple_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co       = c[CHUNK];
        c_msb_in = c[CHUNK-1];
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, least-significant
// chunk first, carrying between chunks through a single flop.
//
// Optional macro SERIAL_CHUNK_ADDER_OVF_EN adds the 'ovf' output (signed
// two's-complement overflow of the final result).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake
//   a, b, cin, sub    : operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready : result handshake
//   sum, cout         : result and carry out (sub mode: 1 = no borrow)
//   ovf               : signed overflow (only with SERIAL_CHUNK_ADDER_OVF_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (never on in_valid); out_valid
// stays high with sum/cout stable until out_ready is seen. Valid signals
// seen while the other side is not ready are ignored, not queued.
// ---------------------------------------------------------------------------
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, cout_q;
    logic             accept, last_chunk;

    logic [CHUNK-1:0] x_chunk, y_chunk, s_chunk;
    logic             co_chunk, c_msb_in;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = (state_q == IDLE) && !rst;
        out_valid  = (state_q == DONE);
        accept     = in_valid && in_ready;
        last_chunk = (idx_q == LAST_IDX);
        case (state_q)
            IDLE:    if (accept)     state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    assign x_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign y_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

    ripple_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x        (x_chunk),
        .y        (y_chunk),
        .ci       (carry_q),
        .s        (s_chunk),
        .co       (co_chunk),
        .c_msb_in (c_msb_in)
    );

    // Subtraction is folded in at capture time: b is inverted and the
    // carry flop is preset to 1, so BUSY only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                BUSY: begin
                    sum_q[int'(idx_q)*CHUNK +: CHUNK] <= s_chunk;
                    carry_q <= co_chunk;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_chunk) cout_q <= co_chunk;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst)                           ovf_q <= 1'b0;
        else if (state_q == BUSY && last_chunk) ovf_q <= co_chunk ^ c_msb_in;
    end

    assign ovf = ovf_q;
`else
    logic unused_c_msb_in;
    assign unused_c_msb_in = c_msb_in;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // ---------------- main DUT (16/4) ----------------
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  logic        ovf;
`endif

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- sweep DUTs: (8,1), (8,8), (32,8) ----------------
  logic        s_valid;
  logic [31:0] s_a, s_b;
  logic        s_cin, s_sub;
  logic        s_out_ready;
  logic        r81, r88, r328;
  logic        v81, v88, v328;
  logic [7:0]  sum81, sum88;
  logic [31:0] sum328;
  logic        c81, c88, c328;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  logic        o81, o88, o328;
`endif

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u81 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r81),
    .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
    .out_valid(v81), .out_ready(s_out_ready), .sum(sum81), .cout(c81)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    , .ovf(o81)
`endif
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r88),
    .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
    .out_valid(v88), .out_ready(s_out_ready), .sum(sum88), .cout(c88)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    , .ovf(o88)
`endif
  );

  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u328 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r328),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .out_valid(v328), .out_ready(s_out_ready), .sum(sum328), .cout(c328)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    , .ovf(o328)
`endif
  );

  // ---------------- driver tasks (main DUT) ----------------
  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_add();
    int lat;
    @(posedge clk); #1;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 4) $display("FAIL add_wrap_latency: got %0d expected 4", lat); else passes++;
    checks++; if (sum !== 16'h0000) $display("FAIL add_wrap_sum: got %h expected 0000", sum); else passes++;
    checks++; if (cout !== 1'b1) $display("FAIL add_wrap_cout: got %b expected 1", cout); else passes++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL add_wrap_drop_valid: got %b expected 0", out_valid); else passes++;
    // carry-in participates in add mode
    start_op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    wait_done(lat);
    checks++; if (sum !== 16'h2234) $display("FAIL add_cin_sum: got %h expected 2234", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL add_cin_cout: got %b expected 0", cout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int lat;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (sum !== 16'hFFFE) $display("FAIL sub_borrow_sum: got %h expected fffe", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL sub_borrow_cout: got %b expected 0", cout); else passes++;
    @(posedge clk); #1;
    // cin must be ignored in sub mode
    start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_done(lat);
    checks++; if (sum !== 16'h0002) $display("FAIL sub_noborrow_sum: got %h expected 0002", sum); else passes++;
    checks++; if (cout !== 1'b1) $display("FAIL sub_noborrow_cout: got %b expected 1", cout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    // new operands offered while BUSY and DONE must not be taken
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_busy_in_ready: got %b expected 0", in_ready); else passes++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) $display("FAIL bp_latency: got %0d expected 4", lat); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b expected 1", out_valid); else passes++;
      checks++; if (sum !== 16'h1000) $display("FAIL bp_hold_sum: got %h expected 1000", sum); else passes++;
      checks++; if (cout !== 1'b0) $display("FAIL bp_hold_cout: got %b expected 0", cout); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready: got %b expected 0", in_ready); else passes++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (sum !== 16'h1000) $display("FAIL bp_idle_sum: got %h expected 1000", sum); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_in_ready: got %b expected 1", in_ready); else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    checks++; if (lat !== 4) $display("FAIL bp_second_latency: got %0d expected 4", lat); else passes++;
    checks++; if (sum !== 16'hBBBB) $display("FAIL bp_second_sum: got %h expected bbbb", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL bp_second_cout: got %b expected 0", cout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (sum !== 16'h0000) $display("FAIL midrst_sum: got %h expected 0000", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL midrst_cout: got %b expected 0", cout); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b expected 0", in_ready); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_idle: got %b expected 1", in_ready); else passes++;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 4) $display("FAIL midrst_next_latency: got %0d expected 4", lat); else passes++;
    checks++; if (sum !== 16'h3333) $display("FAIL midrst_next_sum: got %h expected 3333", sum); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL midrst_next_cout: got %b expected 0", cout); else passes++;
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (sum !== 16'h8000) $display("FAIL ovf_add_sum: got %h expected 8000", sum); else passes++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_add_ovf: got %b expected 1", ovf); else passes++;
    checks++; if (cout !== 1'b0) $display("FAIL ovf_add_cout: got %b expected 0", cout); else passes++;
    @(posedge clk); #1;
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (sum !== 16'h7FFF) $display("FAIL ovf_sub_sum: got %h expected 7fff", sum); else passes++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_sub_ovf: got %b expected 1", ovf); else passes++;
    checks++; if (cout !== 1'b1) $display("FAIL ovf_sub_cout: got %b expected 1", cout); else passes++;
    @(posedge clk); #1;
    start_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (sum !== 16'h0007) $display("FAIL ovf_none_sum: got %h expected 0007", sum); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_none_ovf: got %b expected 0", ovf); else passes++;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_param_sweep();
    logic [31:0] da [4];
    logic [31:0] db [4];
    logic        dc [4];
    logic        ds [4];
    logic [7:0]  bb8;
    logic [31:0] bb32;
    logic [8:0]  e8;
    logic [32:0] e32;
    bit          seen81, seen88, seen328;
    int          lat81, lat88, lat328;
    da[0] = 32'hFFFF_FFFF; db[0] = 32'h0000_0001; dc[0] = 1'b0; ds[0] = 1'b0;
    da[1] = 32'h0000_0005; db[1] = 32'h0000_0007; dc[1] = 1'b0; ds[1] = 1'b1;
    da[2] = 32'h1234_5678; db[2] = 32'h0FED_CBA9; dc[2] = 1'b1; ds[2] = 1'b0;
    da[3] = 32'h8000_0000; db[3] = 32'h0000_0001; dc[3] = 1'b1; ds[3] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int w = 0; w < 30 && !(r81 && r88 && r328); w++) begin
        @(posedge clk); #1;
      end
      if (n < 4) begin
        s_a = da[n]; s_b = db[n]; s_cin = dc[n]; s_sub = ds[n];
      end else begin
        s_a = $urandom; s_b = $urandom;
        s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
      end
      bb8  = s_sub ? ~s_b[7:0] : s_b[7:0];
      bb32 = s_sub ? ~s_b : s_b;
      e8   = {1'b0, s_a[7:0]} + {1'b0, bb8} + {8'd0, (s_sub ? 1'b1 : s_cin)};
      e32  = {1'b0, s_a} + {1'b0, bb32} + {32'd0, (s_sub ? 1'b1 : s_cin)};
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_a = $urandom; s_b = $urandom;
      seen81 = 0; seen88 = 0; seen328 = 0;
      lat81 = 0; lat88 = 0; lat328 = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (v81 && !seen81) begin
          seen81 = 1; lat81 = k;
          checks++; if ({c81, sum81} !== e8) $display("FAIL sweep_8_1 op%0d: got %h expected %h", n, {c81, sum81}, e8); else passes++;
        end
        if (v88 && !seen88) begin
          seen88 = 1; lat88 = k;
          checks++; if ({c88, sum88} !== e8) $display("FAIL sweep_8_8 op%0d: got %h expected %h", n, {c88, sum88}, e8); else passes++;
        end
        if (v328 && !seen328) begin
          seen328 = 1; lat328 = k;
          checks++; if ({c328, sum328} !== e32) $display("FAIL sweep_32_8 op%0d: got %h expected %h", n, {c328, sum328}, e32); else passes++;
        end
      end
      checks++; if (lat81 !== 8) $display("FAIL sweep_8_1_latency op%0d: got %0d expected 8", n, lat81); else passes++;
      checks++; if (lat88 !== 1) $display("FAIL sweep_8_8_latency op%0d: got %0d expected 1", n, lat88); else passes++;
      checks++; if (lat328 !== 4) $display("FAIL sweep_32_8_latency op%0d: got %0d expected 4", n, lat328); else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    test_ovf();
`endif
    test_param_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
